// File: rtl/cdb_receiver_if.sv
// CDB completion-packet type and the write-back handshake interface.
// Ports (interface): wb_valid (packet offered), wb_ready (receiver accepts), wb_pkt (fu_wb_t).
// master = functional-unit side, slave = receiver side.

// Shared machine widths and the completion-packet layout.
localparam int PHYS_W  = 6;
localparam int ROB_W   = 5;
localparam int EPOCH_W = 2;

typedef struct packed {
  logic [ROB_W-1:0]   rob_idx;
  logic [EPOCH_W-1:0] epoch;
  logic               uses_rd;
  logic [PHYS_W-1:0]  prd_new;
  logic [31:0]        data;
  logic               data_valid;
  logic               is_branch;
  logic               mispredict;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               is_load;
  logic               is_store;
  logic [31:0]        pc;
} fu_wb_t;

interface cdb_receiver_if;
  logic   wb_valid;
  logic   wb_ready;
  fu_wb_t wb_pkt;

  modport master (output wb_valid, output wb_pkt, input wb_ready);
  modport slave  (input wb_valid, input wb_pkt, output wb_ready);
endinterface

// File: rtl/cdb_receiver.sv
// Purpose: buffers CDB completion packets and drains them to PRF write, wakeup, ROB-done and redirect.
// Latency: a packet pushed at edge t drives its drain outputs in the cycle after edge t.
// Backpressure: wb_ready = !full && !flush; the drain side pops every non-empty cycle, never stalls.
// Ports: clk, rst (async, active-high); wb (cdb_receiver_if.slave); cur_epoch; flush;
//   prf_we/prf_waddr/prf_wdata; wakeup_valid/wakeup_tag; rob_done_valid/idx/mispredict;
//   redirect_valid/redirect_pc; stat_accepted/stat_dropped only with CDB_RECEIVER_STATS_EN.
// Optional feature macro: CDB_RECEIVER_STATS_EN (accepted/dropped packet counters).

module cdb_receiver #(
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  cdb_receiver_if.slave       wb,
  input  logic [EPOCH_W-1:0]  cur_epoch,
  input  logic                flush,
  output logic                prf_we,
  output logic [PHYS_W-1:0]   prf_waddr,
  output logic [31:0]         prf_wdata,
  output logic                wakeup_valid,
  output logic [PHYS_W-1:0]   wakeup_tag,
  output logic                rob_done_valid,
  output logic [ROB_W-1:0]    rob_done_idx,
  output logic                rob_done_mispredict,
  output logic                redirect_valid,
  output logic [31:0]         redirect_pc
`ifdef CDB_RECEIVER_STATS_EN
  ,
  output logic [31:0]         stat_accepted,
  output logic [31:0]         stat_dropped
`endif
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  fu_wb_t mem [DEPTH];
  ptr_t   head_q, head_d, tail_q, tail_d;
  cnt_t   cnt_q, cnt_d;
  fu_wb_t head_pkt;
  logic   empty, full, push, pop, live;
  logic   unused_fields;

  assign empty       = (cnt_q == '0);
  assign full        = (cnt_q == cnt_t'(DEPTH));
  // No pass-through when full: a same-cycle pop does not reopen the input.
  assign wb.wb_ready = !full && !flush;
  assign push        = wb.wb_valid && wb.wb_ready;
  assign pop         = !empty;
  assign head_pkt    = mem[head_q];
  // Stale (wrong-epoch) heads and heads under flush still pop but drive nothing.
  assign live        = !empty && !flush && (head_pkt.epoch == cur_epoch);

  assign unused_fields = ^{head_pkt.is_load, head_pkt.is_store, head_pkt.pc};

  always_comb begin
    prf_we              = 1'b0;
    prf_waddr           = '0;
    prf_wdata           = '0;
    wakeup_valid        = 1'b0;
    wakeup_tag          = '0;
    rob_done_valid      = 1'b0;
    rob_done_idx        = '0;
    rob_done_mispredict = 1'b0;
    redirect_valid      = 1'b0;
    redirect_pc         = '0;
    if (live) begin
      rob_done_valid      = 1'b1;
      rob_done_idx        = head_pkt.rob_idx;
      rob_done_mispredict = head_pkt.mispredict;
      if (head_pkt.uses_rd && head_pkt.data_valid) begin
        prf_we       = 1'b1;
        prf_waddr    = head_pkt.prd_new;
        prf_wdata    = head_pkt.data;
        wakeup_valid = 1'b1;
        wakeup_tag   = head_pkt.prd_new;
      end
      if (head_pkt.is_branch && head_pkt.redirect) begin
        redirect_valid = 1'b1;
        redirect_pc    = head_pkt.redirect_pc;
      end
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
    end else if (redirect_valid) begin
      // Everything younger than the redirecting branch is wrong-path, including this cycle's push.
      head_d = head_q + 1'b1;
      tail_d = head_q + 1'b1;
      cnt_d  = '0;
    end else begin
      if (pop)  head_d = head_q + 1'b1;
      if (push) tail_d = tail_q + 1'b1;
      cnt_d = cnt_q + cnt_t'(push) - cnt_t'(pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail_q] <= wb.wb_pkt;
  end

`ifdef CDB_RECEIVER_STATS_EN
  logic [31:0] acc_q, drop_q, drop_inc;

  always_comb begin
    drop_inc = '0;
    if (flush) begin
      drop_inc = 32'(cnt_q);
    end else if (redirect_valid) begin
      // Entries behind the head plus the push squashed in the same cycle.
      drop_inc = 32'(cnt_q) - 32'd1 + 32'(push);
    end else if (pop && !live) begin
      drop_inc = 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      acc_q  <= acc_q + 32'(push);
      drop_q <= drop_q + drop_inc;
    end
  end

  assign stat_accepted = acc_q;
  assign stat_dropped  = drop_q;
`endif

endmodule
